// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator memory-bank arbiter.
package accel_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous FIFO of requester ids, one entry per outstanding read.
// Push is refused when full and pop is ignored when empty.
module arb_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_REQ requesters,
// with bounded bursts and an in-order tag FIFO steering read data back to its issuer.
module mem_bank_arbiter
  import accel_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_W    = 5,
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*BANK_W-1:0]   req_bank,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic [BANK_W-1:0]           mem_bank,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_orphan
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    fifo_head;
  logic [CNT_W-1:0]   beat_cnt;
  logic               in_grant;
  logic               owner_we;
  logic               stall;
  logic               accept;
  logic               burst_end;
  logic               tag_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic               rsp_hit;
  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0] rotated;
  int unsigned        offset;

  assign in_grant  = (state == ARB_GRANT);
  assign owner_we  = req_we[owner];
  assign stall     = in_grant && !owner_we && fifo_full;
  assign mem_valid = in_grant && req_valid[owner] && !stall;
  assign accept    = mem_valid && mem_ready;
  assign burst_end = accept && (req_last[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1)));
  assign tag_push  = accept && !owner_we;

  assign mem_we    = in_grant && owner_we;
  assign mem_addr  = in_grant ? req_addr[owner*ADDR_W +: ADDR_W]   : '0;
  assign mem_wdata = in_grant ? req_wdata[owner*DATA_W +: DATA_W] : '0;
  assign mem_bank  = in_grant ? req_bank[owner*BANK_W +: BANK_W]   : '0;
  assign grant_id  = owner;

  always_comb begin
    req_ready = '0;
    if (in_grant && mem_ready && !stall) begin
      req_ready[owner] = 1'b1;
    end
  end

  // Rotate so the requester after rr_ptr lands at bit 0, take the lowest set bit,
  // then rotate the offset back into an absolute requester id.
  assign doubled = {req_valid, req_valid};

  always_comb begin
    rotated = NUM_REQ'(doubled >> (32'(rr_ptr) + 32'd1));
    offset  = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (rotated[k-1]) begin
        offset = k - 1;
      end
    end
    pick_id = ID_W'((32'(rr_ptr) + 32'd1 + offset) % NUM_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            owner    <= pick_id;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (burst_end) begin
            rr_ptr <= owner;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  arb_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (RSP_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .pop   (mem_rvalid),
    .din   (owner),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign rsp_hit   = mem_rvalid && !fifo_empty;
  assign rsp_rdata = rsp_hit ? mem_rdata : '0;
  assign busy      = in_grant || !fifo_empty;

  always_comb begin
    rsp_valid = '0;
    if (rsp_hit) begin
      rsp_valid[fifo_head] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (mem_rvalid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Self-checking bench for mem_bank_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level reference model.
module tb_mem_bank_arbiter;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int BW    = 5;
  localparam int MB    = 8;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_we;
  logic [N*BW-1:0] req_bank;
  logic [N-1:0]    req_last;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [BW-1:0]   mem_bank;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_orphan;

  mem_bank_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BANK_W    (BW),
    .MAX_BURST (MB),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_bank   (req_bank),
    .req_last   (req_last),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_bank   (mem_bank),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, how many beats it has moved, who went
  // last, and the ids of reads still waiting for data, oldest first.
  bit m_granted;
  int m_owner;
  int m_beats;
  int m_rr;
  int m_q[$];
  bit m_orphan;

  typedef struct packed {
    logic [3:0] v, we, last;
    logic       mr, rv;
    logic [1:0] gid;
    logic       mv;
    logic [3:0] rdy, rsp;
    logic       busy, orph;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] v, we, last, logic mr, rv, logic [1:0] gid,
                              logic mv, logic [3:0] rdy, rsp, logic bsy, orph);
    vec_t r;
    r = '{v, we, last, mr, rv, gid, mv, rdy, rsp, bsy, orph};
    return r;
  endfunction

  task automatic model_reset();
    m_granted = 0;
    m_owner   = 0;
    m_beats   = 0;
    m_rr      = N - 1;
    m_q.delete();
    m_orphan  = 0;
  endtask

  task automatic check_model();
    logic [N-1:0]  e_rdy, e_rsp;
    logic          e_mv, e_stall, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [BW-1:0] e_bank;
    e_rdy = '0; e_rsp = '0; e_mv = 0; e_stall = 0; e_we = 0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_bank = '0;
    if (m_granted) begin
      e_stall = !req_we[m_owner] && (m_q.size() == DEPTH);
      e_mv    = req_valid[m_owner] && !e_stall;
      if (mem_ready && !e_stall) e_rdy[m_owner] = 1'b1;
      e_we   = req_we[m_owner];
      e_addr = req_addr[m_owner*AW +: AW];
      e_wd   = req_wdata[m_owner*DW +: DW];
      e_bank = req_bank[m_owner*BW +: BW];
    end
    if (mem_rvalid && m_q.size() > 0) begin
      e_rsp[m_q[0]] = 1'b1;
      e_rd = mem_rdata;
    end
    chk("mem_valid", 64'(mem_valid), 64'(e_mv));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("grant_id", 64'(grant_id), 64'(m_owner));
    chk("mem_payload", {mem_we, mem_bank, mem_addr, mem_wdata}, {e_we, e_bank, e_addr, e_wd});
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    chk("busy", 64'(busy), 64'(m_granted || m_q.size() > 0));
    chk("err_orphan", 64'(err_orphan), 64'(m_orphan));
  endtask

  task automatic model_update();
    int sz;
    bit acc;
    bit found;
    sz  = m_q.size();
    acc = m_granted && req_valid[m_owner] && mem_ready && !(!req_we[m_owner] && sz == DEPTH);
    if (mem_rvalid) begin
      if (sz > 0) void'(m_q.pop_front());
      else m_orphan = 1;
    end
    if (acc && !req_we[m_owner]) m_q.push_back(m_owner);
    if (!m_granted) begin
      if (|req_valid) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            found   = 1;
          end
        end
        m_granted = 1;
        m_beats   = 0;
      end
    end else if (acc) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_granted = 0;
        m_rr      = m_owner;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v, we, last, input logic mr, rv);
    req_valid  = v;
    req_we     = we;
    req_last   = last;
    mem_ready  = mr;
    mem_rvalid = rv;
    mem_rdata  = $urandom;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = $urandom;
      req_bank[i*BW +: BW]  = BW'($urandom);
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, we, last, input logic mr, rv);
    drive(v, we, last, mr, rv);
    #1;
    check_model();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    #1;
    check_model();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[16];
    int   ids[$];
    int   at[$];
    int   exp_ids[$];
    int   n0, n1, r1, npulse;
    bit   r3done;
    logic [N-1:0] exp_rsp [4];

    rst = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0);
    rand_payload();
    model_reset();

    // Requester 0 streams reads into a tag FIFO nobody drains until it fills.
    tbl[0]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 4'b0000, 0, 0);
    tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[2]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[3]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[4]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[5]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 4'b0000, 1, 0);
    tbl[6]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0001, 1, 0);
    tbl[7]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[8]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0001, 1, 0);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0001, 4'b0000, 1, 0);
    tbl[10] = mk(4'b0001, 4'b0000, 4'b0001, 1, 1, 2'd0, 1, 4'b0001, 4'b0001, 1, 0);
    tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0001, 1, 0);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0001, 1, 0);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0001, 1, 0);
    tbl[14] = mk(4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 0, 4'b0000, 4'b0000, 0, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 4'b0000, 0, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].last, tbl[i].mr, tbl[i].rv);
      #1;
      chk($sformatf("vec%0d.grant_id", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("vec%0d.mem_valid", i), 64'(mem_valid), 64'(tbl[i].mv));
      chk($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d.rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rsp));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d.err_orphan", i), 64'(err_orphan), 64'(tbl[i].orph));
      tick();
    end

    // Single requester: req 2 reads three beats, then gets three responses.
    do_reset();
    cyc(4'b0100, 4'b0000, 4'b0000, 1, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      cyc(4'b0100, 4'b0000, (b == 2) ? 4'b0100 : 4'b0000, 1, 0);
      chk("single.grant_id", 64'(grant_id), 64'd2);
      chk("single.accept", 64'(mem_valid && mem_ready), 64'd1);
      tick();
    end
    cyc(4'b0000, 4'b0000, 4'b0000, 1, 0);
    chk("single.idle_mem_valid", 64'(mem_valid), 64'd0);
    tick();
    npulse = 0;
    for (int b = 0; b < 3; b++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 1, 1);
      if (rsp_valid == 4'b0100) npulse++;
      tick();
    end
    chk("single.rsp_pulses", 64'(npulse), 64'd3);

    // All four requesting single-beat writes: strict rotation with a bubble between grants.
    do_reset();
    ids.delete(); at.delete();
    for (int c = 0; c < 12; c++) begin
      cyc(4'b1111, 4'b1111, 4'b1111, 1, 0);
      if (mem_valid && mem_ready) begin
        ids.push_back(int'(grant_id));
        at.push_back(c);
      end
      tick();
    end
    chk("rr.count", 64'(ids.size() >= 5), 64'd1);
    for (int j = 0; j < 5 && j < ids.size(); j++) begin
      chk($sformatf("rr.order%0d", j), 64'(ids[j]), 64'(j % N));
      if (j > 0) chk($sformatf("rr.gap%0d", j), 64'(at[j] - at[j-1]), 64'd2);
    end

    // Burst cap: req 1 has 12 beats with no early last, req 3 waits with one beat.
    do_reset();
    ids.delete();
    r1 = 0;
    r3done = 0;
    for (int c = 0; c < 40 && (r1 < 12 || !r3done); c++) begin
      cyc({!r3done, 1'b0, r1 < 12, 1'b0}, 4'b1111, {1'b1, 1'b0, r1 == 11, 1'b0}, 1, 0);
      if (mem_valid && mem_ready) begin
        ids.push_back(int'(grant_id));
        if (grant_id == 2'd1) r1++;
        else if (grant_id == 2'd3) r3done = 1;
      end
      tick();
    end
    exp_ids = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 1};
    chk("cap.beats", 64'(ids.size()), 64'(exp_ids.size()));
    for (int j = 0; j < exp_ids.size() && j < ids.size(); j++) begin
      chk($sformatf("cap.owner%0d", j), 64'(ids[j]), 64'(exp_ids[j]));
    end

    // Mixed owners: two reads each from req 0 then req 1, responses in issue order.
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 20 && (n0 < 2 || n1 < 2); c++) begin
      cyc({2'b00, n1 < 2, n0 < 2}, 4'b0000, {2'b00, n1 == 1, n0 == 1}, 1, 0);
      if (mem_valid && mem_ready) begin
        if (grant_id == 2'd0) n0++;
        else n1++;
      end
      tick();
    end
    exp_rsp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010};
    for (int j = 0; j < 4; j++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 1, 1);
      chk($sformatf("mixed.rsp_valid%0d", j), 64'(rsp_valid), 64'(exp_rsp[j]));
      chk($sformatf("mixed.rsp_rdata%0d", j), 64'(rsp_rdata), 64'(mem_rdata));
      tick();
    end
    cyc(4'b0000, 4'b0000, 4'b0000, 1, 0);
    chk("mixed.no_orphan", 64'(err_orphan), 64'd0);
    tick();

    // Reset asserted mid-burst clears outputs at once; a late response is an orphan.
    do_reset();
    cyc(4'b0100, 4'b0000, 4'b0000, 1, 0);
    tick();
    cyc(4'b0100, 4'b0000, 4'b0000, 1, 0);
    tick();
    drive(4'b0100, 4'b0000, 4'b0000, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid.mem_valid", 64'(mem_valid), 64'd0);
    chk("rstmid.req_ready", 64'(req_ready), 64'd0);
    chk("rstmid.grant_id", 64'(grant_id), 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid.mem_addr", 64'(mem_addr), 64'd0);
    chk("rstmid.err_orphan", 64'(err_orphan), 64'd0);
    model_reset();
    drive(4'b0000, 4'b0000, 4'b0000, 1, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model();
    tick();
    cyc(4'b0000, 4'b0000, 4'b0000, 1, 0);
    chk("rstmid.late_orphan", 64'(err_orphan), 64'd1);
    tick();
    for (int j = 0; j < 3; j++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 1, 0);
      chk("orphan.sticky", 64'(err_orphan), 64'd1);
      tick();
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v, we, last;
      for (int i = 0; i < N; i++) begin
        v[i]    = ($urandom_range(0, 9) < 6);
        we[i]   = $urandom_range(0, 1);
        last[i] = ($urandom_range(0, 3) == 0);
      end
      rand_payload();
      cyc(v, we, last, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
      tick();
      if (c == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Shares the single memory-controller request port between `NUM_REQ` accelerator controllers. It uses round-robin arbitration with bounded bursts. Read responses return in order, and a tag FIFO routes each response back to the requester that issued it. The block sits between the per-accelerator sequencers and the banked memory controller.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `BANK_W`, 5: bank-select width.
- `MAX_BURST`, 8: maximum beats per grant (≥1).
- `RSP_DEPTH`, 4: outstanding-read tag FIFO depth (power of 2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: request beat valid, per requester.
- `req_ready` out NUM_REQ: beat accepted, per requester.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester i occupies slice i.
- `req_wdata` in NUM_REQ*DATA_W: packed write data.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_bank` in NUM_REQ*BANK_W: packed bank selects.
- `req_last` in NUM_REQ: final beat of the burst.
- `mem_valid` out 1, `mem_ready` in 1: downstream handshake.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1, `mem_bank` out BANK_W: the owner's request.
- `mem_rvalid` in 1, `mem_rdata` in DATA_W: in-order read return.
- `rsp_valid` out NUM_REQ: read data valid, one-hot to the issuing requester.
- `rsp_rdata` out DATA_W: broadcast read data.
- `grant_id` out $clog2(NUM_REQ): current owner.
- `busy` out 1: state is GRANT or reads are outstanding.
- `err_orphan` out 1: sticky flag, cleared only by reset.

## Operation
- **FSM ARB_IDLE:** if any `req_valid` is high, pick the first valid requester scanning upward from `rr_ptr+1` (wrapping). Register it as owner, clear the beat counter, and go to ARB_GRANT.
- **FSM ARB_GRANT:** drive `mem_*` from the owner's slices; `mem_valid` = owner `req_valid` && !stall.
  - stall = owner is reading (`req_we`=0) && tag FIFO full. A push is refused when the FIFO is full even if a pop happens in the same cycle.
  - `req_ready[owner]` = `mem_ready` && !stall. All other `req_ready` bits are 0.
  - A beat is accepted when `mem_valid` && `mem_ready`. The beat counter increments, and a read beat pushes the owner id into the tag FIFO.
- **Burst end:** on an accepted beat with `req_last` high, or on the accepted beat where the count reaches MAX_BURST:
  - set `rr_ptr` to the owner;
  - go to ARB_IDLE.
- **Owner withdraws:** if the owner drops `req_valid` mid-burst, stay in GRANT; no timeout.
- **Response path:** when `mem_rvalid` is high, pop the FIFO head, assert `rsp_valid[head]`, and pass `rsp_rdata` = `mem_rdata`. All of this is combinational.
- **Orphan response:** `mem_rvalid` with the FIFO empty raises `err_orphan`; the data is dropped and no `rsp_valid` is asserted.
- Writes generate no response and never touch the FIFO.

## Timing
- **Reset values:**
  - all outputs 0;
  - FSM in ARB_IDLE;
  - `rr_ptr` = NUM_REQ-1, so requester 0 wins first;
  - FIFO empty, beat counter 0.
- **Arbitration latency:** a request in IDLE at cycle N gives `grant_id` and `mem_valid` at cycle N+1. The first beat can be accepted in cycle N+1.
- **Burst gap:** one mandatory IDLE bubble cycle after each burst. Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- **Response latency:** `rsp_valid` follows `mem_rvalid` with zero cycles of latency.
- **Simultaneous push and pop:** allowed when the FIFO is not full; the occupancy is unchanged.
- **Reset mid-operation:** the grant, FIFO and flag clear immediately. Any late `mem_rvalid` after reset sets `err_orphan`.
- **Fairness:** a continuously requesting requester waits at most (NUM_REQ-1)·(MAX_BURST+1) cycles for a grant.

## Structure
- **Shared package** (`accel_pkg`) holds:
  - `arb_state_e` {ARB_IDLE, ARB_GRANT};
  - a localparam for the default MAX_BURST.
- **Sub-module `arb_tag_fifo`:** synchronous FIFO of owner ids.
  - Parameters: width and depth.
  - Ports: push, pop, full, empty, head.
  - Occupancy counter has $clog2(DEPTH)+1 bits.
- The round-robin pick is a rotate-and-priority-encode inside the top module.

## Test plan
- **Single requester:** req 2 reads 3 beats with `req_last` on beat 3 and `mem_ready`=1.
  - `grant_id`=2 one cycle after the request.
  - 3 accepts, then IDLE.
  - 3 `rsp_valid[2]` pulses when `mem_rvalid` is driven.
- **All four requesting continuously:** each with 1-beat bursts carrying `req_last`.
  - Grant order 0,1,2,3,0.
  - One bubble cycle between grants.
- **Burst cap:** req 1 issues 12 beats with no `req_last` and MAX_BURST=8.
  - The grant ends after beat 8.
  - Req 3 (also waiting) is granted next.
  - Req 1 then regains the grant for its remaining 4 beats.
- **FIFO full:** 4 reads accepted with `mem_rvalid` held at 0.
  - The 5th read sees `mem_valid`=0 and `req_ready`=0.
  - One `mem_rvalid` unblocks it in the following cycle.
- **Mixed owners:** req 0 issues 2 reads, then req 1 issues 2 reads; responses return in order.
  - `rsp_valid` pattern is 0,0,1,1.
  - `rsp_rdata` matches `mem_rdata`.
- **Orphan response:** `mem_rvalid` with the FIFO empty sets `err_orphan`, which stays set until `rst`.
- **Reset mid-burst:** assert `rst` during a burst; all outputs go to 0 asynchronously.
